// File: rtl/stride_prefetcher.sv
// Single-stream stride prefetcher: learns a constant line stride from demand
// misses and pushes DEGREE line-aligned prefetch addresses into a queue.
module stride_prefetcher #(
    parameter int ADDR_WIDTH   = 32,
    parameter int BLOCK_OFFSET = 6,
    parameter int DEGREE       = 2,
    parameter int CONF_MAX     = 3,
    parameter int CONF_THRESH  = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  miss_valid,
    input  logic [ADDR_WIDTH-1:0] miss_addr,
    input  logic                  queue_full,
    output logic                  pf_push,
    output logic [ADDR_WIDTH-1:0] pf_addr,
    output logic                  busy
);

    localparam int B  = ADDR_WIDTH - BLOCK_OFFSET;
    localparam int CW = $clog2(CONF_MAX + 1);
    localparam int IW = $clog2(DEGREE + 1);

    localparam logic [CW-1:0] CONF_MAX_C    = CW'(CONF_MAX);
    localparam logic [CW-1:0] CONF_THRESH_C = CW'(CONF_THRESH);
    localparam logic [IW-1:0] DEGREE_C      = IW'(DEGREE);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TRAIN = 2'd1,
        ISSUE = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [B-1:0]  last_blk_q, last_blk_d;
    logic [B-1:0]  stride_q, stride_d;
    logic [CW-1:0] conf_q, conf_d;
    logic [B-1:0]  next_blk_q, next_blk_d;
    logic [IW-1:0] issue_cnt_q, issue_cnt_d;

    logic [B-1:0]  blk;
    logic [B-1:0]  delta;
    logic [CW-1:0] conf_upd;
    logic          unused_low_bits;

    assign blk             = miss_addr[ADDR_WIDTH-1:BLOCK_OFFSET];
    assign delta           = blk - last_blk_q;
    assign unused_low_bits = ^miss_addr[BLOCK_OFFSET-1:0];

    assign pf_push = (state_q == ISSUE) && !queue_full;
    assign pf_addr = {next_blk_q, {BLOCK_OFFSET{1'b0}}};
    assign busy    = (state_q == ISSUE);

    always_comb begin
        state_d     = state_q;
        last_blk_d  = last_blk_q;
        stride_d    = stride_q;
        conf_d      = conf_q;
        next_blk_d  = next_blk_q;
        issue_cnt_d = issue_cnt_q;
        conf_upd    = conf_q;

        unique case (state_q)
            IDLE: begin
                if (miss_valid) begin
                    last_blk_d = blk;
                    stride_d   = '0;
                    conf_d     = '0;
                    state_d    = TRAIN;
                end
            end
            TRAIN, ISSUE: begin
                if (pf_push) begin
                    next_blk_d  = next_blk_q + stride_q;
                    issue_cnt_d = issue_cnt_q + 1'b1;
                    if (issue_cnt_q + 1'b1 == DEGREE_C) begin
                        state_d = TRAIN;
                    end
                end
                // Same-line misses carry no stride information.
                if (miss_valid && (delta != '0)) begin
                    if (delta == stride_q) begin
                        conf_upd = (conf_q == CONF_MAX_C) ? conf_q
                                                          : conf_q + 1'b1;
                    end else begin
                        conf_upd = '0;
                        stride_d = delta;
                    end
                    conf_d     = conf_upd;
                    last_blk_d = blk;
                    if (conf_upd >= CONF_THRESH_C) begin
                        state_d     = ISSUE;
                        next_blk_d  = blk + delta;
                        issue_cnt_d = '0;
                    end else begin
                        state_d = TRAIN;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            last_blk_q  <= '0;
            stride_q    <= '0;
            conf_q      <= '0;
            next_blk_q  <= '0;
            issue_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            last_blk_q  <= last_blk_d;
            stride_q    <= stride_d;
            conf_q      <= conf_d;
            next_blk_q  <= next_blk_d;
            issue_cnt_q <= issue_cnt_d;
        end
    end

endmodule

// File: tb/tb_stride_prefetcher.sv
// Directed bench for stride_prefetcher: training, issue, backpressure,
// retraining, wrap and reset behaviour.
module tb_stride_prefetcher;

    logic        clk;
    logic        reset;
    logic        miss_valid;
    logic [31:0] miss_addr;
    logic        queue_full;
    logic        pf_push;
    logic [31:0] pf_addr;
    logic        busy;

    int n_checks;
    int n_fails;

    stride_prefetcher dut (
        .clk        (clk),
        .reset      (reset),
        .miss_valid (miss_valid),
        .miss_addr  (miss_addr),
        .queue_full (queue_full),
        .pf_push    (pf_push),
        .pf_addr    (pf_addr),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        miss_valid = 1'b0;
        miss_addr  = '0;
        queue_full = 1'b0;
        reset      = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        #1;
    endtask

    task automatic do_miss(input logic [31:0] a);
        miss_valid = 1'b1;
        miss_addr  = a;
        tick();
        miss_valid = 1'b0;
        #1;
    endtask

    task automatic expect_out(input string tag, input logic push,
                              input logic [31:0] addr, input logic bsy);
        chk({tag, "_push"}, {31'b0, pf_push}, {31'b0, push});
        chk({tag, "_addr"}, pf_addr, addr);
        chk({tag, "_busy"}, {31'b0, busy}, {31'b0, bsy});
    endtask

    initial begin
        n_checks = 0;
        n_fails  = 0;
        do_reset();
        expect_out("reset", 1'b0, 32'h0, 1'b0);

        // Ascending stream
        do_miss(32'h1000);
        do_miss(32'h1040);
        do_miss(32'h1080);
        expect_out("asc_pre", 1'b0, 32'h0, 1'b0);
        do_miss(32'h10C0);
        expect_out("asc_p0", 1'b1, 32'h1100, 1'b1);
        tick();
        expect_out("asc_p1", 1'b1, 32'h1140, 1'b1);
        tick();
        chk("asc_done_push", {31'b0, pf_push}, 32'h0);
        chk("asc_done_busy", {31'b0, busy}, 32'h0);

        // Backpressure
        do_reset();
        do_miss(32'h1000);
        do_miss(32'h1040);
        do_miss(32'h1080);
        queue_full = 1'b1;
        do_miss(32'h10C0);
        for (int i = 0; i < 5; i++) begin
            expect_out("bp_hold", 1'b0, 32'h1100, 1'b1);
            tick();
        end
        queue_full = 1'b0;
        #1;
        expect_out("bp_p0", 1'b1, 32'h1100, 1'b1);
        tick();
        expect_out("bp_p1", 1'b1, 32'h1140, 1'b1);
        tick();
        chk("bp_done_push", {31'b0, pf_push}, 32'h0);

        // Descending stream
        do_reset();
        do_miss(32'h2000);
        do_miss(32'h1FC0);
        do_miss(32'h1F80);
        do_miss(32'h1F40);
        expect_out("desc_p0", 1'b1, 32'h1F00, 1'b1);
        tick();
        expect_out("desc_p1", 1'b1, 32'h1EC0, 1'b1);
        tick();
        chk("desc_done_busy", {31'b0, busy}, 32'h0);

        // Same-line repeats leave training untouched
        do_reset();
        do_miss(32'h1000);
        do_miss(32'h1008);
        do_miss(32'h1030);
        do_miss(32'h1000);
        expect_out("same_idle", 1'b0, 32'h0, 1'b0);
        do_miss(32'h1040);
        do_miss(32'h1080);
        expect_out("same_pre", 1'b0, 32'h0, 1'b0);
        do_miss(32'h10C0);
        expect_out("same_p0", 1'b1, 32'h1100, 1'b1);

        // Address wrap
        do_reset();
        do_miss(32'hFFFFFF40);
        do_miss(32'hFFFFFF80);
        do_miss(32'hFFFFFFC0);
        do_miss(32'h00000000);
        expect_out("wrap_p0", 1'b1, 32'h00000040, 1'b1);
        tick();
        expect_out("wrap_p1", 1'b1, 32'h00000080, 1'b1);
        tick();

        // Mismatching miss during ISSUE drops back to TRAIN
        do_reset();
        do_miss(32'h1000);
        do_miss(32'h1040);
        do_miss(32'h1080);
        queue_full = 1'b1;
        do_miss(32'h10C0);
        chk("rt_busy", {31'b0, busy}, 32'h1);
        do_miss(32'h5000);
        chk("rt_train_busy", {31'b0, busy}, 32'h0);
        queue_full = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("rt_nopush", {31'b0, pf_push}, 32'h0);
            tick();
        end
        // stride is now 0x140-0x43 with conf 0: one stride-1 miss cannot trigger
        do_miss(32'h5040);
        chk("rt_conf0", {31'b0, busy}, 32'h0);

        // Matching miss during ISSUE restarts the issue
        do_reset();
        do_miss(32'h1000);
        do_miss(32'h1040);
        do_miss(32'h1080);
        do_miss(32'h10C0);
        miss_valid = 1'b1;
        miss_addr  = 32'h1100;
        #1;
        expect_out("rs_p0", 1'b1, 32'h1100, 1'b1);
        tick();
        miss_valid = 1'b0;
        #1;
        expect_out("rs_p1", 1'b1, 32'h1140, 1'b1);
        tick();
        expect_out("rs_p2", 1'b1, 32'h1180, 1'b1);
        tick();
        chk("rs_done_push", {31'b0, pf_push}, 32'h0);
        chk("rs_done_busy", {31'b0, busy}, 32'h0);

        // Reset mid-ISSUE
        do_reset();
        do_miss(32'h1000);
        do_miss(32'h1040);
        do_miss(32'h1080);
        do_miss(32'h10C0);
        chk("mr_push", {31'b0, pf_push}, 32'h1);
        reset = 1'b1;
        tick();
        expect_out("mr_after", 1'b0, 32'h0, 1'b0);
        reset = 1'b0;
        #1;
        do_miss(32'h1000);
        do_miss(32'h1040);
        do_miss(32'h1080);
        expect_out("mr_3miss", 1'b0, 32'h0, 1'b0);
        do_miss(32'h10C0);
        expect_out("mr_4miss", 1'b1, 32'h1100, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/stride_prefetcher.md
# stride_prefetcher

Single-stream stride prefetch generator feeding the prefetch request queue. It watches demand-miss line addresses from the cache controller and learns a constant line stride with a saturating confidence counter. Once confident, it pushes DEGREE line-aligned prefetch addresses into the downstream queue through that queue's push/full interface. It stalls on full and never drops a request.

## Interface
- ADDR_WIDTH, 32, byte address width
- BLOCK_OFFSET, 6, log2 of line size in bytes; block number = addr[ADDR_WIDTH-1:BLOCK_OFFSET]
- DEGREE, 2, prefetches issued per trigger (>=1)
- CONF_MAX, 3, confidence saturation value
- CONF_THRESH, 2, confidence needed to trigger issue (1..CONF_MAX)

Ports:
- clk  input  1  clock; all state updates on posedge
- reset  input  1  synchronous, active-high
- miss_valid  input  1  demand miss observed this cycle
- miss_addr  input  ADDR_WIDTH  byte address of the miss; low BLOCK_OFFSET bits ignored
- queue_full  input  1  downstream queue full
- pf_push  output  1  push to queue, sampled on posedge
- pf_addr  output  ADDR_WIDTH  line-aligned prefetch address; low BLOCK_OFFSET bits are 0
- busy  output  1  high while in ISSUE

## Operation
- State registers:
  - last_blk: block width B = ADDR_WIDTH-BLOCK_OFFSET.
  - stride: B bits, two's complement.
  - conf: saturating counter, 0..CONF_MAX.
  - next_blk: B bits.
  - issue_cnt: counts 0..DEGREE.
- FSM states: IDLE, TRAIN, ISSUE.
- blk = miss_addr >> BLOCK_OFFSET. delta = blk - last_blk, mod 2^B.
- A miss with delta == 0 while in TRAIN or ISSUE is ignored. No register changes.
- IDLE, on miss: last_blk <= blk, stride <= 0, conf <= 0; go to TRAIN.
- TRAIN/ISSUE, on miss with delta != 0:
  - delta == stride: conf <= min(conf+1, CONF_MAX).
  - Otherwise: stride <= delta, conf <= 0.
  - In both cases, last_blk <= blk.
  - If the updated conf >= CONF_THRESH: state <= ISSUE, next_blk <= blk + delta, issue_cnt <= 0. This restarts the issue when already in ISSUE.
  - Otherwise: state <= TRAIN. This aborts any remaining issue.
- ISSUE, no retraining miss:
  - pf_push = (state == ISSUE) && !queue_full, combinational.
  - On each accepted push: next_blk <= next_blk + stride, issue_cnt <= issue_cnt + 1.
  - When issue_cnt reaches DEGREE: go to TRAIN.
- Miss and push in the same cycle: the push with the current pf_addr completes. The miss update then takes priority for next_blk, issue_cnt and state.
- pf_addr = {next_blk, BLOCK_OFFSET'b0} in all states.
- Arithmetic wraps mod 2^B. No page-boundary or wrap suppression.
- busy = (state == ISSUE).

## Timing
- Reset:
  - Outputs: pf_push=0, busy=0, pf_addr=0.
  - Registers: state=IDLE; last_blk, stride, conf, next_blk, issue_cnt all 0.
  - Reset asserted mid-ISSUE: pf_push is 0 in the cycle after the reset edge; all training is lost.
- Trigger latency: a miss that raises conf to CONF_THRESH at edge k makes pf_push high during cycle k+1, if !queue_full. The queue accepts the request at edge k+1.
- Throughput: one prefetch per cycle while not full. DEGREE pushes take DEGREE cycles with no backpressure.
- Backpressure: while queue_full=1, pf_push=0 and pf_addr holds stable. Issue resumes in the first cycle queue_full=0.
- Minimum training: CONF_THRESH+2 distinct-line misses from IDLE. The first miss sets the base, the second sets the stride, and each further matching miss adds one to conf.

## Test plan
1. Ascending stream. Defaults; misses 0x1000, 0x1040, 0x1080, 0x10C0 on consecutive cycles. Required: pf_push high on 2 cycles starting the cycle after the 4th miss, pf_addr 0x1100 then 0x1140, then busy=0.
2. Backpressure. As test 1, with queue_full=1 for 5 cycles from the trigger. Required: pf_push=0 and pf_addr=0x1100 steady throughout. After release: pushes of 0x1100 and 0x1140 on consecutive cycles.
3. Descending stream. Misses 0x2000, 0x1FC0, 0x1F80, 0x1F40. Required: stride=-1; pushes 0x1F00 then 0x1EC0.
4. Same-line repeats and wrap. Misses 0x1000, 0x1008, 0x1030. Required: no state change after the first miss. Separately, stream 0xFFFFFF40, 0xFFFFFF80, 0xFFFFFFC0, 0x00000000. Required: pushes 0x00000040 and 0x00000080.
5. Retrain during ISSUE. Trigger as in test 1, hold queue_full=1, then miss 0x5000. Required: TRAIN state, conf=0, no further pushes after release. A matching miss during ISSUE, 0x1100 after the trigger, instead restarts issue at 0x1140 with a fresh count of DEGREE.
6. Reset mid-ISSUE. Assert reset during the first push cycle. Required: pf_push=0, busy=0, pf_addr=0 next cycle. Afterwards 3 matching misses cause no push; a 4th is needed.
